// File: rtl/univ_reg.sv
// univ_reg: WIDTH-bit universal register with hold, load, shift, rotate and up/down count.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (q=RESET_VAL, carry=0)
//   clr   - synchronous clear, overrides we and mode
//   we    - write enable; register holds when low
//   mode  - 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 INC, 111 DEC
//   din   - parallel load data
//   sin   - serial input for SHL/SHR
//   q     - register contents
//   sout  - q[WIDTH-1] in SHL, q[0] otherwise
//   carry - registered carry/borrow/shifted-out bit
//   zero  - high when q is 0
module univ_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SATURATE  = 1'b0
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             we,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             carry,
   output logic             zero
);
   logic [WIDTH-1:0] r_q;
   logic             r_c;
   logic [WIDTH-1:0] w_nq;
   logic             w_nc;
   logic [WIDTH:0]   w_inc;
   logic [WIDTH:0]   w_dec;
   // Shifts and counts pack {carry, q} or {q, carry} so the bit leaving q lands in carry.
   always_comb begin
      w_inc = {1'b0, r_q} + 1'b1;
      w_dec = {1'b0, r_q} - 1'b1;
      w_nq  = r_q;
      w_nc  = r_c;
      case (mode)
         3'b001:  begin w_nq = din; w_nc = 1'b0; end
         3'b010:  {w_nc, w_nq} = {r_q, sin};
         3'b011:  {w_nq, w_nc} = {sin, r_q};
         3'b100:  {w_nc, w_nq} = {r_q, r_q[WIDTH-1]};
         3'b101:  {w_nq, w_nc} = {r_q[0], r_q};
         3'b110:  {w_nc, w_nq} = (SATURATE && &r_q) ? {1'b1, r_q} : w_inc;
         3'b111:  {w_nc, w_nq} = (SATURATE && r_q == '0) ? {1'b1, r_q} : w_dec;
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= RESET_VAL;
         r_c <= 1'b0;
      end else if (clr) begin
         r_q <= '0;
         r_c <= 1'b0;
      end else if (we) begin
         r_q <= w_nq;
         r_c <= w_nc;
      end
   end
   assign q     = r_q;
   assign carry = r_c;
   assign zero  = (r_q == '0);
   assign sout  = (mode == 3'b010) ? r_q[WIDTH-1] : r_q[0];
endmodule

// File: tb/tb_univ_reg.sv
// tb_univ_reg: self-checking bench for univ_reg, wrapping and saturating instances side by side.
module tb_univ_reg;
   logic       clk = 1'b0;
   logic       rst_n, clr, we, sin;
   logic [2:0] mode;
   logic [7:0] din;
   logic [7:0] q0, q1;
   logic       sout0, sout1, c0, c1, z0, z1;
   int         mq0, mc0, mq1, mc1;
   int         pass_cnt = 0;
   int         total = 0;

   always #5 clk = ~clk;

   univ_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .SATURATE(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .mode(mode), .din(din), .sin(sin),
      .q(q0), .sout(sout0), .carry(c0), .zero(z0));
   univ_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .SATURATE(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .mode(mode), .din(din), .sin(sin),
      .q(q1), .sout(sout1), .carry(c1), .zero(z1));

   // Reference: register value as an integer 0..255, operations as plain arithmetic.
   function automatic void model(inout int q, inout int c, input bit sat);
      if (clr) begin
         q = 0;
         c = 0;
      end else if (we) begin
         case (mode)
            3'd1: begin q = int'(din); c = 0; end
            3'd2: begin c = q / 128; q = (q * 2) % 256 + int'(sin); end
            3'd3: begin c = q % 2; q = q / 2 + int'(sin) * 128; end
            3'd4: begin c = q / 128; q = (q * 2) % 256 + q / 128; end
            3'd5: begin c = q % 2; q = q / 2 + (q % 2) * 128; end
            3'd6: if (q == 255) begin c = 1; q = sat ? 255 : 0; end else begin c = 0; q = q + 1; end
            3'd7: if (q == 0) begin c = 1; q = sat ? 0 : 255; end else begin c = 0; q = q - 1; end
            default: ;
         endcase
      end
   endfunction

   task automatic drive(input bit c, input bit w, input logic [2:0] m, input logic [7:0] d, input bit s);
      clr = c; we = w; mode = m; din = d; sin = s;
   endtask

   task automatic step();
      if (!clr && we && $isunknown(mode)) begin
         total++;
         $display("FAIL mode_x: mode=%b with we=1 clr=0", mode);
      end
      @(posedge clk);
      model(mq0, mc0, 1'b0);
      model(mq1, mc1, 1'b1);
      #1;
   endtask

   task automatic test_reset();
      drive(0, 1, 3'd1, 8'h77, 0);
      step();
      #2 rst_n = 1'b0;
      mq0 = 8'hA5; mc0 = 0; mq1 = 8'hA5; mc1 = 0;
      #1;
      total++; if (q0 !== 8'hA5) $display("FAIL reset_q0 got %h want a5", q0); else pass_cnt++;
      total++; if (q1 !== 8'hA5) $display("FAIL reset_q1 got %h want a5", q1); else pass_cnt++;
      total++; if (c0 !== 1'b0) $display("FAIL reset_carry got %b want 0", c0); else pass_cnt++;
      total++; if (z0 !== 1'b0) $display("FAIL reset_zero got %b want 0", z0); else pass_cnt++;
      #1 rst_n = 1'b1;
   endtask

   task automatic test_load();
      drive(0, 1, 3'd1, 8'h3C, 0);
      step();
      total++; if (q0 !== 8'h3C) $display("FAIL load_q got %h want 3c", q0); else pass_cnt++;
      total++; if (c0 !== 1'b0) $display("FAIL load_carry got %b want 0", c0); else pass_cnt++;
   endtask

   task automatic test_we_gating();
      drive(0, 0, 3'd6, 8'h00, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         total++; if (q0 !== 8'h3C) $display("FAIL we_hold_q%0d got %h want 3c", i, q0); else pass_cnt++;
         total++; if (c0 !== 1'b0) $display("FAIL we_hold_c%0d got %b want 0", i, c0); else pass_cnt++;
      end
   endtask

   task automatic test_shift_rotate();
      logic [2:0] t_mode [4] = '{3'd2, 3'd3, 3'd5, 3'd4};
      bit         t_sin  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [7:0] t_q    [4] = '{8'h02, 8'h81, 8'hC0, 8'h81};
      bit         t_c    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      drive(0, 1, 3'd1, 8'h81, 0);
      step();
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, t_mode[i], 8'h00, t_sin[i]);
         step();
         total++; if (q0 !== t_q[i]) $display("FAIL shift_q%0d got %h want %h", i, q0, t_q[i]); else pass_cnt++;
         total++; if (c0 !== t_c[i]) $display("FAIL shift_c%0d got %b want %b", i, c0, t_c[i]); else pass_cnt++;
         total++; if (sout0 !== ((t_mode[i] == 3'd2) ? t_q[i][7] : t_q[i][0]))
            $display("FAIL shift_sout%0d got %b mode %0d q %h", i, sout0, t_mode[i], t_q[i]); else pass_cnt++;
      end
   endtask

   task automatic test_wrap_count();
      drive(0, 1, 3'd1, 8'hFE, 0);
      step();
      drive(0, 1, 3'd6, 8'h00, 0);
      step();
      total++; if (q0 !== 8'hFF || c0 !== 1'b0) $display("FAIL inc1 got %h/%b want ff/0", q0, c0); else pass_cnt++;
      step();
      total++; if (q0 !== 8'h00 || c0 !== 1'b1) $display("FAIL inc_wrap got %h/%b want 00/1", q0, c0); else pass_cnt++;
      total++; if (z0 !== 1'b1) $display("FAIL inc_wrap_zero got %b want 1", z0); else pass_cnt++;
      total++; if (q1 !== 8'hFF || c1 !== 1'b1) $display("FAIL sat_no_wrap got %h/%b want ff/1", q1, c1); else pass_cnt++;
      drive(0, 1, 3'd7, 8'h00, 0);
      step();
      total++; if (q0 !== 8'hFF || c0 !== 1'b1) $display("FAIL dec_borrow got %h/%b want ff/1", q0, c0); else pass_cnt++;
      total++; if (q1 !== 8'hFE || c1 !== 1'b0) $display("FAIL sat_dec got %h/%b want fe/0", q1, c1); else pass_cnt++;
   endtask

   task automatic test_saturate();
      drive(0, 1, 3'd1, 8'hFF, 0);
      step();
      drive(0, 1, 3'd6, 8'h00, 0);
      step();
      total++; if (q1 !== 8'hFF || c1 !== 1'b1) $display("FAIL sat_inc got %h/%b want ff/1", q1, c1); else pass_cnt++;
      drive(0, 1, 3'd1, 8'h00, 0);
      step();
      drive(0, 1, 3'd7, 8'h00, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (q1 !== 8'h00 || c1 !== 1'b1) $display("FAIL sat_dec%0d got %h/%b want 00/1", i, q1, c1); else pass_cnt++;
         total++; if (z1 !== 1'b1) $display("FAIL sat_dec_zero%0d got %b want 1", i, z1); else pass_cnt++;
      end
   endtask

   task automatic test_clear();
      drive(0, 1, 3'd1, 8'h55, 0);
      step();
      drive(1, 1, 3'd1, 8'hAA, 1);
      step();
      total++; if (q0 !== 8'h00 || c0 !== 1'b0) $display("FAIL clr_q got %h/%b want 00/0", q0, c0); else pass_cnt++;
      total++; if (z0 !== 1'b1) $display("FAIL clr_zero got %b want 1", z0); else pass_cnt++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(15) == 0, $urandom_range(3) != 0, 3'($urandom_range(7)),
               8'($urandom), 1'($urandom));
         step();
         total++; if (q0 !== 8'(mq0) || c0 !== 1'(mc0))
            $display("FAIL rnd_wrap%0d got %h/%b want %h/%b", i, q0, c0, 8'(mq0), 1'(mc0)); else pass_cnt++;
         total++; if (q1 !== 8'(mq1) || c1 !== 1'(mc1))
            $display("FAIL rnd_sat%0d got %h/%b want %h/%b", i, q1, c1, 8'(mq1), 1'(mc1)); else pass_cnt++;
         total++; if (z0 !== (mq0 == 0) || z1 !== (mq1 == 0))
            $display("FAIL rnd_zero%0d got %b%b want %b%b", i, z0, z1, mq0 == 0, mq1 == 0); else pass_cnt++;
         total++; if (sout0 !== 1'((mode == 3'd2) ? mq0 / 128 : mq0 % 2))
            $display("FAIL rnd_sout%0d got %b mode %0d q %h", i, sout0, mode, 8'(mq0)); else pass_cnt++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 3'd0, 8'h00, 0);
      mq0 = 8'hA5; mc0 = 0; mq1 = 8'hA5; mc1 = 0;
      #3 rst_n = 1'b1;
      test_reset();
      test_load();
      test_we_gating();
      test_shift_rotate();
      test_wrap_count();
      test_saturate();
      test_clear();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/univ_reg.md
Name: univ_reg

Overview:
- Parametrised successor to the team's single-bit write-enabled register: a WIDTH-bit universal register.
- Supports hold, parallel load, logical shift, rotate and up/down count, gated by write enable.
- Provides a synchronous clear, a registered carry/borrow flag, a combinational zero flag and serial I/O.
- Used as a general datapath register, shift stage or loop counter.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 64.
- RESET_VAL, 0, value loaded into q on asynchronous reset; truncated to WIDTH bits.
- SATURATE, 0, when 1, increment and decrement clamp at the limits instead of wrapping.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; takes priority over we and mode.
- we  input  1  write enable; when 0 the register holds regardless of mode.
- mode  input  3  operation select, encoded under Behaviour.
- din  input  WIDTH  parallel load data.
- sin  input  1  serial input bit for shift modes.
- q  output  WIDTH  register contents.
- sout  output  1  combinational; q[WIDTH-1] when mode=SHL, otherwise q[0].
- carry  output  1  registered carry, borrow or shifted-out bit.
- zero  output  1  combinational; 1 when q equals 0.

Behaviour:
- Reset: rst_n=0 asynchronously forces q=RESET_VAL and carry=0, independent of clk. On release, the first active clk edge operates normally.
- Priority at each rising clk edge: clr, then we=0, then mode.
- clr=1: q=0 and carry=0, whatever the values of we and mode.
- we=0 (clr=0): q and carry hold.
- mode encoding, when we=1 and clr=0:
  - 000 HOLD: q and carry unchanged.
  - 001 LOAD: q=din; carry=0.
  - 010 SHL: q={q[W-2:0],sin}; carry=old q[W-1].
  - 011 SHR: q={sin,q[W-1:1]}; carry=old q[0].
  - 100 ROL: q={q[W-2:0],q[W-1]}; carry=old q[W-1].
  - 101 ROR: q={q[0],q[W-1:1]}; carry=old q[0].
  - 110 INC: q=q+1 modulo 2^WIDTH.
    - carry=1 only on the all-ones to 0 wrap; otherwise 0.
    - SATURATE=1: at all-ones, q stays all-ones and carry=1.
  - 111 DEC: q=q-1 modulo 2^WIDTH.
    - carry=1 only on the 0 to all-ones borrow; otherwise 0.
    - SATURATE=1: at 0, q stays 0 and carry=1.
- Latency: one clock. q and carry reflect an operation on the edge after the inputs are sampled.
- zero and sout follow q and mode combinationally, with no extra cycle.
- Arithmetic is unsigned. There is no overflow beyond the carry flag, and the internal sum width is WIDTH+1.
- Inputs are sampled only at the rising clk edge. Glitches between edges, including on we, have no effect.
- Reset asserted mid-operation (for example during a count run) aborts immediately. There is no recovery of the prior value.
- X on mode while we=1 and clr=0 is illegal. The bench flags it; RTL behaviour is unspecified.

Test Plan:
- Reset and load (WIDTH=8, RESET_VAL=8'hA5):
  - Assert rst_n=0 mid-cycle -> q=A5, carry=0, zero=0 without a clk edge.
  - Release, LOAD din=3C with we=1 -> q=3C one edge later.
- Write enable gating: load q=3C, then we=0 with mode=INC for 5 edges -> q stays 3C and carry is unchanged.
- Shift and rotate, starting from q=81:
  - SHL, sin=0 -> q=02, carry=1.
  - SHR, sin=1 -> q=81, carry=0.
  - ROR -> q=C0, carry=1.
  - ROL -> q=81, carry=1.
- Wrap counting (SATURATE=0):
  - Load FE, INC x2 -> q=FF with carry=0, then q=00 with carry=1 and zero=1.
  - DEC -> q=FF, carry=1.
- Saturating counting (SATURATE=1):
  - Load FF, INC -> q=FF, carry=1.
  - Load 00, DEC x3 -> q=00 and carry=1 each edge.
- Clear priority: q=55, clr=1 with we=1 and mode=LOAD din=AA on the same edge -> q=00, carry=0, zero=1.
